sseg_scan_ctrl: RTL and testbench
=================================

# sseg_scan_ctrl

Scan controller for the board's 8-digit common-anode seven-segment display. It sequences the digit strobes with a fixed per-digit on-time and an inter-digit blanking gap to suppress ghosting. It applies per-digit enables and leading-zero suppression. Writes are double-buffered so a new value only takes effect at a frame boundary, which prevents tearing. It sits between the counter/debounce logic that produces display values and the AN/SSEG pins.

## Interface
- DIGIT_CYCLES, 50_000: clk cycles each digit is driven (1 ms at 50 MHz); must be >= 1.
- BLANK_CYCLES, 1_000: clk cycles with all anodes off after each digit; 0 removes the BLANK state.
- NUM_DIGITS, 8: digits scanned; fixed at 8 for this board.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- hex_in  in  32  digit values; digit i = hex_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  8  decimal point per digit; 1 = lit.
- digit_en  in  8  per-digit enable; 1 = digit may light.
- lz_blank  in  1  1 = suppress leading zeros.
- load  in  1  1-cycle strobe; captures hex_in/dp_in/digit_en/lz_blank into the staging registers.
- an  out  8  active-low anode strobes; at most one bit is 0.
- sseg  out  8  active-low segments; [6:0] = {a,b,c,d,e,f,g}; [7] = dp.
- frame_start  out  1  1-cycle pulse on the first cycle of the digit-0 slot.

## Operation
- States:
  - SCAN(idx): digit idx driven for DIGIT_CYCLES cycles.
  - BLANK(idx): an=8'hFF and sseg=8'hFF for BLANK_CYCLES cycles.
- Sequence:
  - SCAN(i) -> BLANK(i) -> SCAN(i+1 mod 8).
  - When BLANK_CYCLES=0, SCAN(i) -> SCAN(i+1) directly.
- Slots are never skipped. Disabled or suppressed digits still consume their slot with an=8'hFF, so a frame is always 8*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- A digit is dark when either condition holds:
  - active digit_en[i]=0;
  - active lz_blank=1, i != 0, and all nibbles i..7 of the active hex are 0.
- Digit 0 is never suppressed, so 0x00000000 shows "0".
- Decode table, sseg[6:0]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- sseg[7] = ~dp_in[i] for a lit digit. It is 1 for a dark digit and in BLANK.
- Buffering:
  - load writes the staging registers and sets pending.
  - On entry to SCAN(0), if pending is set, staging is copied to active and pending clears.
  - A load in the same cycle as SCAN(0) entry goes to staging only; it is applied at the next frame.
  - Back-to-back loads: the last one wins.
- Reset values:
  - an=8'hFF, sseg=8'hFF, frame_start=0.
  - Active and staging registers: hex=0, dp=0, en=8'hFF, lz_blank=0; pending=0.
  - State BLANK(7), counter 0.

## Timing
- an, sseg and frame_start are registered from next-state, so they change on the same edge as the state register. They are glitch-free.
- After reset deasserts, the first an=8'hFE appears on rising edge BLANK_CYCLES+1 (edge 1 when BLANK_CYCLES=0), together with frame_start=1.
- The load-to-display latency is variable. A load becomes visible at the next SCAN(0) entry, at most one frame plus one cycle later.
- Reset mid-operation: an and sseg go to 8'hFF asynchronously. Pending staged data is discarded.
- Slot counter: width $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)). It counts 0..N-1 and clears on every state change, with no wrap beyond N-1.

## Structure
- The shared package sseg_pkg holds:
  - SEG_BLANK = 8'hFF;
  - AN_OFF = 8'hFF;
  - the state enum {SCAN, BLANK};
  - the 16-entry decode constants.
- Sub-module hex_to_sseg is purely combinational: 4-bit hex in, 7-bit active-low segments out. It is instantiated once on the muxed active nibble.
- The FSM, counter, staging/active registers and leading-zero logic live in sseg_scan_ctrl.

## Test plan
All scenarios use DIGIT_CYCLES=4, BLANK_CYCLES=2.
- Reset release:
  - stimulus: release reset;
  - response: an=FF for edges 1–2; an=FE with frame_start=1 at edge 3 and sseg=8'h81 (digit 0, value 0); an=FE held 4 cycles, then FF for 2, then FD; frame period 48 cycles.
- Leading-zero suppression:
  - stimulus: load hex=0x000000A5, lz_blank=1, en=FF;
  - response: next frame shows digit 0 sseg=8'hA4 and digit 1 sseg=8'h88; slots 2–7 have an=FF.
- Decimal point:
  - stimulus: dp_in=8'h01, hex=0x12345678;
  - response: sseg[7]=0 only while an=FE; slot 7 shows 8'hCF ("1").
- Double buffering:
  - stimulus: load new hex during SCAN(3);
  - response: slots 3–7 still show the old digits; the new value appears from the next frame_start.
  - stimulus: load in the same cycle as SCAN(0) entry;
  - response: the value is applied one frame later.
- Digit enables:
  - stimulus: digit_en=8'h0F;
  - response: an=FF during slots 4–7; frame still 48 cycles; frame_start period unchanged.
- Reset mid-scan:
  - stimulus: assert reset during SCAN(5) with a load pending;
  - response: an=sseg=FF immediately; after release the display shows 0 (digit 0 lit, sseg=8'h81, others 0 with en=FF), and the staged value never appears.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, bit order {a,b,c,d,e,f,g}.
package sseg_pkg;

  localparam int unsigned DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    SCAN,
    BLANK
  } state_e;

  // Index 0 is the rightmost (lowest) entry.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef struct packed {
    logic [4*DIGITS-1:0] hex;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
    logic                lz_blank;
  } disp_cfg_t;

  localparam disp_cfg_t CFG_RESET = '{hex: '0, dp: '0, en: '1, lz_blank: 1'b0};

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with blanking gaps,
// per-digit enables, leading-zero suppression and frame-synchronous updates.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_start
);

  localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q;
  disp_cfg_t             stage_q, stage_d, active_q, active_d;
  logic                  pending_q, pending_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            sseg_d;
  logic                  enter_scan0;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  upper_zero;
  logic                  dig_lit;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;

  assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // The reset BLANK(7) holds one extra cycle so the first digit-0 slot
  // lands BLANK_CYCLES+1 edges after reset release.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      SCAN: begin
        if (cnt_q == DIGIT_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d = idx_inc;
          end else begin
            state_d = BLANK;
          end
        end
      end
      default: begin
        if (BLANK_CYCLES == 0 || (run_q && cnt_q == BLANK_LAST)) begin
          state_d = SCAN;
          idx_d   = idx_inc;
          cnt_d   = '0;
        end else if (!run_q) begin
          cnt_d = cnt_q;
        end
      end
    endcase
  end

  assign enter_scan0 = (state_d == SCAN) && (idx_d == '0) && !((state_q == SCAN) && (idx_q == '0));

  always_comb begin
    stage_d   = load ? disp_cfg_t'{hex: hex_in, dp: dp_in, en: digit_en, lz_blank: lz_blank}
                     : stage_q;
    active_d  = (enter_scan0 && pending_q) ? stage_q : active_q;
    pending_d = load | (pending_q & ~enter_scan0);
  end

  always_comb begin
    zero_from  = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero && (active_d.hex[4*i +: 4] == 4'h0);
      zero_from[i] = upper_zero;
    end
  end

  // Outputs decode the next state and next active set so they switch with the state.
  assign nibble  = active_d.hex[{idx_d, 2'b00} +: 4];
  assign dig_lit = active_d.en[idx_d] &&
                   !(active_d.lz_blank && (idx_d != '0) && zero_from[idx_d]);

  hex_to_sseg u_dec (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_comb begin
    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    if (state_d == SCAN && dig_lit) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_d);
      sseg_d = {~active_d.dp[idx_d], seg_dec};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BLANK;
      idx_q       <= IDX_LAST;
      cnt_q       <= '0;
      run_q       <= 1'b0;
      stage_q     <= CFG_RESET;
      active_q    <= CFG_RESET;
      pending_q   <= 1'b0;
      an          <= AN_OFF;
      sseg        <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      run_q       <= 1'b1;
      stage_q     <= stage_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      an          <= an_d;
      sseg        <= sseg_d;
      frame_start <= enter_scan0;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench: stimulus queues whole expected frames, a monitor checks
// each frame slot by slot as frame_start marks its beginning.
module tb_sseg_scan_ctrl;

  localparam int unsigned DC    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned SLOT  = DC + BC;
  localparam int unsigned FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hex_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .NUM_DIGITS   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hex_in      (hex_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .lz_blank    (lz_blank),
    .load        (load),
    .an          (an),
    .sseg        (sseg),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [7:0][7:0] an;
    logic [7:0][7:0] sseg;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic frame_t mkf(input logic [63:0] a, input logic [63:0] s);
    frame_t f;
    f.an   = a;
    f.sseg = s;
    return f;
  endfunction

  // Hand-decoded frames, slot 7 in the top byte.
  localparam logic [63:0] AN_ALL = 64'h7FBF_DFEF_F7FB_FDFE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  int cyc = 0;
  bit seen = 0;
  bit have_exp = 0;
  int mon_slot, mon_off;

  always @(negedge clk) begin
    if (reset) begin
      seen     = 0;
      have_exp = 0;
      cyc      = 0;
    end else begin
      if (frame_start) begin
        if (seen) chk("frame_period", 64'(cyc), 64'(FRAME));
        seen = 1;
        cyc  = 0;
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_exp = 1;
        end else begin
          have_exp = 0;
        end
      end
      if (seen && have_exp && cyc < FRAME) begin
        mon_slot = cyc / SLOT;
        mon_off  = cyc % SLOT;
        if (mon_off == 0 || mon_off == DC - 1) begin
          chk($sformatf("slot%0d_off%0d_an", mon_slot, mon_off), 64'(an), 64'(cur.an[mon_slot]));
          chk($sformatf("slot%0d_off%0d_sseg", mon_slot, mon_off), 64'(sseg),
              64'(cur.sseg[mon_slot]));
        end else if (mon_off == DC) begin
          chk($sformatf("slot%0d_blank", mon_slot), {an, sseg}, 64'hFFFF);
        end
        if (cyc == 1) chk("frame_start_width", 64'(frame_start), 64'd0);
      end
      if (seen && cyc > FRAME + 12) begin
        chk("frame_watchdog", 64'(cyc), 64'(FRAME));
        seen = 0;
      end
      cyc++;
    end
  end

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    if (!frame_start) chk("wait_frame_start_timeout", 64'(n), 64'd0);
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] d, input logic [7:0] e,
                         input logic lz);
    hex_in   = h;
    dp_in    = d;
    digit_en = e;
    lz_blank = lz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic release_and_check();
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= BC; e++) begin
      @(negedge clk);
      chk($sformatf("rel_edge%0d_an", e), 64'(an), 64'hFF);
      chk($sformatf("rel_edge%0d_fs", e), 64'(frame_start), 64'd0);
    end
    @(negedge clk);
    chk("rel_first_fs", 64'(frame_start), 64'd1);
    chk("rel_first_an", 64'(an), 64'hFE);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", 64'(an), 64'hFF);
    chk("reset_sseg", 64'(sseg), 64'hFF);
    chk("reset_fs", 64'(frame_start), 64'd0);

    // F1: reset contents, every digit shows "0".
    exp_q.push_back(mkf(AN_ALL, 64'h8181_8181_8181_8181));
    release_and_check();

    // F2: leading-zero suppression of 0x000000A5.
    exp_q.push_back(mkf(64'hFFFF_FFFF_FFFF_FDFE, 64'hFFFF_FFFF_FFFF_88A4));
    do_load(32'h0000_00A5, 8'h00, 8'hFF, 1'b1);

    // F3: decimal point on digit 0 only.
    wait_fs();
    exp_q.push_back(mkf(AN_ALL, 64'hCF92_86CC_A4A0_8F00));
    do_load(32'h1234_5678, 8'h01, 8'hFF, 1'b0);

    // F4: load during SCAN(3) of F3; F3 must stay the old value throughout.
    wait_fs();
    exp_q.push_back(mkf(AN_ALL, 64'h8488_E0B1_C2B0_B881));
    repeat (3 * SLOT + 1) @(negedge clk);
    do_load(32'h9ABC_DEF0, 8'h00, 8'hFF, 1'b0);

    // Load sampled on the SCAN(0) entry edge: F5 unchanged, F6 gets it.
    wait_fs();
    exp_q.push_back(mkf(AN_ALL, 64'h8488_E0B1_C2B0_B881));
    repeat (FRAME - 1) @(negedge clk);
    exp_q.push_back(mkf(64'hFFFF_FFFF_F7FB_FDFE, 64'hFFFF_FFFF_8692_CF81));
    do_load(32'h7654_3210, 8'h00, 8'h0F, 1'b0);
    chk("same_edge_fs", 64'(frame_start), 64'd1);

    // F7: back-to-back loads, last wins; all-zero value shows a single "0".
    wait_fs();
    exp_q.push_back(mkf(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF81));
    do_load(32'hFFFF_FFFF, 8'hFF, 8'hFF, 1'b0);
    do_load(32'h0000_0000, 8'h00, 8'hFF, 1'b1);

    // F8: decimal point on digit 5.
    wait_fs();
    exp_q.push_back(mkf(AN_ALL, 64'hCF92_06CC_A4A0_8F80));
    do_load(32'h1234_5678, 8'h20, 8'hFF, 1'b0);

    // Reset during SCAN(5) of F8 with a load pending.
    wait_fs();
    do_load(32'h1111_1111, 8'hFF, 8'hFF, 1'b0);
    repeat (5 * SLOT - 1) @(negedge clk);
    chk("pre_reset_an", 64'(an), 64'hDF);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_an", 64'(an), 64'hFF);
    chk("async_reset_sseg", 64'(sseg), 64'hFF);
    chk("async_reset_fs", 64'(frame_start), 64'd0);
    repeat (2) @(negedge clk);

    // Staged 0x11111111 must never appear after reset.
    exp_q.push_back(mkf(AN_ALL, 64'h8181_8181_8181_8181));
    exp_q.push_back(mkf(AN_ALL, 64'h8181_8181_8181_8181));
    release_and_check();
    wait_fs();
    wait_fs();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
